counter_sequencer: RTL

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// Programmable up-counter sequencer with prescaler, periodic/one-shot modes,
// terminal-count pulse and sticky interrupt/overrun flags.
//
//   state  | meaning
//   -------+--------------------------------------------------------
//   S_IDLE | stopped; q holds last value; config writes accepted
//   S_RUN  | counting ticks; config writes rejected with cfg_err
//   S_DONE | one-shot finished; q=0; config writes accepted
module counter_sequencer #(
  parameter int N  = 16,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [N-1:0]  cfg_period,
  input  logic [PW-1:0] cfg_prescale,
  input  logic          cfg_oneshot,
  input  logic          start,
  input  logic          stop,
  input  logic          irq_ack,
  output logic [N-1:0]  q,
  output logic          running,
  output logic          tc,
  output logic          irq,
  output logic          overrun,
  output logic          cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [N-1:0]  r_q;
  logic [N-1:0]  r_period;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] r_prescale;
  logic          r_oneshot;
  logic          r_tc;
  logic          r_irq;
  logic          r_overrun;
  logic          r_cfg_err;

  logic          w_tick;
  logic          w_tc_ev;
  logic          w_start_ok;
  logic          w_stop_run;

  // Next-state decode plus the tick / terminal-count events of this cycle.
  // Stop wins over start and over a coincident tick.
  always_comb begin
    w_state_nxt = r_state;
    w_tick      = 1'b0;
    w_tc_ev     = 1'b0;
    w_start_ok  = 1'b0;
    w_stop_run  = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start && !stop) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_stop_run  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tick = (r_pre == r_prescale);
          if (w_tick && (r_q == r_period)) begin
            w_tc_ev = 1'b1;
            if (r_oneshot) begin
              w_state_nxt = S_DONE;
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counter, prescaler, shadow config and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      r_pre      <= '0;
      r_period   <= '1;
      r_prescale <= '0;
      r_oneshot  <= 1'b0;
      r_tc       <= 1'b0;
      r_irq      <= 1'b0;
      r_overrun  <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_tc      <= w_tc_ev;
      r_cfg_err <= cfg_we && (r_state == S_RUN);

      if (cfg_we && (r_state != S_RUN)) begin
        r_period   <= cfg_period;
        r_prescale <= cfg_prescale;
        r_oneshot  <= cfg_oneshot;
      end

      if (w_start_ok) begin
        r_q   <= '0;
        r_pre <= '0;
      end else if (w_stop_run) begin
        r_pre <= '0;
      end else if (r_state == S_RUN) begin
        if (w_tick) begin
          r_pre <= '0;
          if (w_tc_ev) begin
            r_q <= '0;
          end else begin
            r_q <= r_q + 1'b1;
          end
        end else begin
          r_pre <= r_pre + 1'b1;
        end
      end

      // A terminal count beats a same-cycle acknowledge; in that case the
      // overrun flag is left as it was rather than set or cleared.
      if (w_tc_ev) begin
        r_irq <= 1'b1;
        if (r_irq && !irq_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (irq_ack) begin
        r_irq     <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign q       = r_q;
  assign running = (r_state == S_RUN);
  assign tc      = r_tc;
  assign irq     = r_irq;
  assign overrun = r_overrun;
  assign cfg_err = r_cfg_err;

endmodule
